ysyx_22041207_shift_mul: RTL
============================

# ysyx_22041207_shift_mul

Multi-cycle iterative 64×64 integer multiplier; the responder side of the ALU multiply handshake. Accepts one operand pair via valid/ready, computes the full 128-bit product with shift-add iterations, and returns it with a one-cycle done pulse. Covers RV64M MUL/MULH/MULHSU/MULHU/MULW. Sits beside the ALU in the EX stage and is cancelled by the pipeline flush.

## Interface
Parameters: none.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- mul_valid  input  1  request; operands sampled when mul_valid && mul_ready.
- flush  input  1  synchronous cancel of any request in flight.
- mulw  input  1  32-bit word op (MULW).
- mul_signed  input  2  {a_signed, b_signed}: 11 MUL/MULH, 10 MULHSU, 00 MULHU; 01 treated as 00.
- multiplicand  input  64  operand a (rs1).
- multiplier  input  64  operand b (rs2).
- mul_ready  output  1  idle, can accept.
- out_valid  output  1  one-cycle pulse: result_hi/result_lo valid.
- result_hi  output  64  product bits [127:64]; 0 for mulw.
- result_lo  output  64  product bits [63:0]; mulw: sign-extended product bits [31:0].

## Operation
- FSM states: IDLE, BUSY, DONE. mul_ready = (state==IDLE); out_valid = (state==DONE).
- IDLE: on mul_valid && !flush → latch magnitudes |a|, |b| (two's-complement negate if operand's signed bit set and MSB=1; unsigned magnitude, so -2^63 → 2^63), latch neg = a_neg XOR b_neg, clear 128-bit accumulator, load iteration count N, → BUSY.
- mulw: operands are low 32 bits zero-extended, mul_signed ignored, N halved.
- BUSY: each cycle consume K multiplier LSBs: acc += (b[K-1:0] × |a|) << shift; shift multiplier right K; decrement count. When count reaches 0 → DONE, registering result = neg ? −acc : acc (128-bit negate).
- DONE: out_valid=1 for exactly one cycle, result held; → IDLE. result_hi/result_lo keep their value until the next DONE.
- mul_valid while BUSY/DONE ignored (no queueing); operands need not stay stable after acceptance.
- flush: in IDLE suppresses acceptance (flush wins over mul_valid); in BUSY abandons the operation, → IDLE next cycle, no out_valid ever produced for it; in DONE the pulse already visible stands, state → IDLE as normal.
- rst: overrides everything including flush; → IDLE; out_valid=0, mul_ready=1, result_hi=result_lo=0 after the reset edge. Reset mid-BUSY discards the operation.

## Timing
- Accept in cycle T → BUSY cycles T+1..T+N → out_valid in cycle T+N+1.
- Radix-2 (default, K=1): N=64 (latency 65); mulw N=32 (latency 33).
- mul_ready low from T+1 through T+N+1; high again at T+N+2, so earliest back-to-back accept is T+N+2.
- Flush in cycle F (F in T+1..T+N): state IDLE and mul_ready=1 in F+1; new request acceptable in F+1.

## Configuration
- MUL_RADIX4_EN defined: K=2 per cycle (add 0/1/2/3 × |a|, 3×|a| precomputed at accept); N=32 (latency 33), mulw N=16 (latency 17). Results bit-identical.
- Undefined: radix-2, latencies as above. No other behaviour changes.

## Test plan
- Unsigned: a=3, b=5, mul_signed=00, accept at T → out_valid only at T+65 (T+33 with MUL_RADIX4_EN), result_lo=15, result_hi=0; mul_ready low T+1..T+65.
- Signed: a=-2, b=3, mul_signed=11 → result_lo=0xFFFF_FFFF_FFFF_FFFA, result_hi=0xFFFF_FFFF_FFFF_FFFF; a=b=0x8000_0000_0000_0000 signed → hi=0x4000_0000_0000_0000, lo=0.
- MULHSU: a=-1, b=0xFFFF_FFFF_FFFF_FFFF, mul_signed=10 → hi=0xFFFF_FFFF_FFFF_FFFF, lo=1; MULHU same operands → hi=0xFFFF_FFFF_FFFF_FFFE, lo=1.
- MULW: a=0xDEAD_BEEF_7FFF_FFFF, b=2, mulw=1 → out_valid at T+33, result_lo=0xFFFF_FFFF_FFFF_FFFE, result_hi=0.
- Flush at T+10 → no out_valid in following 100 cycles, mul_ready=1 at T+11; new 6×7 accepted at T+11 → result_lo=42 at T+76. mul_valid held high throughout BUSY causes no second result.
- rst asserted mid-BUSY → next cycle mul_ready=1, out_valid=0, results 0; flush and mul_valid together in IDLE → not accepted.

Source files
------------

// File: rtl/ysyx_22041207_shift_mul.sv
// ysyx_22041207_shift_mul
//   Iterative 64x64 shift-add multiplier that answers the ALU multiply
//   handshake (RV64M MUL/MULH/MULHSU/MULHU/MULW). One operand pair is
//   accepted on mul_valid && mul_ready. The full 128-bit product is then
//   returned with a one-cycle out_valid pulse. A pipeline flush cancels the
//   operation in flight.
//
//   Optional build macro: MUL_RADIX4_EN
//     undefined : 1 multiplier bit per cycle, 64 iterations (MULW: 32)
//     defined   : 2 multiplier bits per cycle, 32 iterations (MULW: 16)
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   mul_valid     request; operands sampled when mul_valid && mul_ready
//   flush         synchronous cancel of a request in flight
//   mulw          32-bit word multiply (MULW)
//   mul_signed    {a_signed, b_signed}; 2'b01 behaves as 2'b00
//   multiplicand  operand a (rs1)
//   multiplier    operand b (rs2)
//   mul_ready     idle and able to accept
//   out_valid     one-cycle pulse; result_hi/result_lo are valid
//   result_hi     product[127:64] (0 for MULW)
//   result_lo     product[63:0] (MULW: sign-extended product[31:0])
module ysyx_22041207_shift_mul (
    input  logic        clk,
    input  logic        rst,
    input  logic        mul_valid,
    input  logic        flush,
    input  logic        mulw,
    input  logic [1:0]  mul_signed,
    input  logic [63:0] multiplicand,
    input  logic [63:0] multiplier,
    output logic        mul_ready,
    output logic        out_valid,
    output logic [63:0] result_hi,
    output logic [63:0] result_lo
);

`ifdef MUL_RADIX4_EN
    localparam int unsigned K      = 2;
    localparam logic [6:0]  N_FULL = 7'd32;
    localparam logic [6:0]  N_WORD = 7'd16;
`else
    localparam int unsigned K      = 1;
    localparam logic [6:0]  N_FULL = 7'd64;
    localparam logic [6:0]  N_WORD = 7'd32;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state, state_nxt;
    logic [127:0] a_reg;      // |a|, shifted left K each iteration
    logic [63:0]  b_reg;      // |b|, shifted right K each iteration
    logic [127:0] acc;
    logic [6:0]   cnt;
    logic         neg;
    logic         w_reg;
`ifdef MUL_RADIX4_EN
    logic [127:0] a3_reg;     // 3*|a|, shifted alongside a_reg
`endif

    logic         accept;
    logic         last;
    logic         a_neg, b_neg;
    logic [63:0]  a_src, b_src, a_mag, b_mag;
    logic [127:0] pp, acc_nxt, prod;

    assign mul_ready = (state == IDLE);
    assign out_valid = (state == DONE);

    assign accept = (state == IDLE) && mul_valid && !flush;
    assign last   = (cnt == 7'd1);

    // Sign handling happens only at accept: the array works on unsigned
    // magnitudes, and the 128-bit result is negated once at the end.
    // The 64-bit negate makes -2^63 map to the unsigned magnitude 2^63.
    assign a_neg = !mulw && mul_signed[1] && multiplicand[63];
    assign b_neg = !mulw && (&mul_signed) && multiplier[63];
    assign a_src = mulw ? {32'b0, multiplicand[31:0]} : multiplicand;
    assign b_src = mulw ? {32'b0, multiplier[31:0]}   : multiplier;
    assign a_mag = a_neg ? (~a_src + 64'd1) : a_src;
    assign b_mag = b_neg ? (~b_src + 64'd1) : b_src;

`ifdef MUL_RADIX4_EN
    always_comb begin
        pp = '0;
        case (b_reg[1:0])
            2'd1:    pp = a_reg;
            2'd2:    pp = a_reg << 1;
            2'd3:    pp = a3_reg;
            default: pp = '0;
        endcase
    end
`else
    assign pp = b_reg[0] ? a_reg : '0;
`endif

    assign acc_nxt = acc + pp;
    assign prod    = neg ? (~acc_nxt + 128'd1) : acc_nxt;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (flush) state_nxt = IDLE;
                     else if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            w_reg     <= 1'b0;
            result_hi <= '0;
            result_lo <= '0;
`ifdef MUL_RADIX4_EN
            a3_reg    <= '0;
`endif
        end else if (accept) begin
            a_reg  <= {64'b0, a_mag};
            b_reg  <= b_mag;
            acc    <= '0;
            cnt    <= mulw ? N_WORD : N_FULL;
            neg    <= a_neg ^ b_neg;
            w_reg  <= mulw;
`ifdef MUL_RADIX4_EN
            a3_reg <= {64'b0, a_mag} + {63'b0, a_mag, 1'b0};
`endif
        end else if (state == BUSY) begin
            acc    <= acc_nxt;
            a_reg  <= a_reg << K;
            b_reg  <= b_reg >> K;
            cnt    <= cnt - 7'd1;
`ifdef MUL_RADIX4_EN
            a3_reg <= a3_reg << K;
`endif
            // A flush on the final iteration still cancels the result.
            if (last && !flush) begin
                if (w_reg) begin
                    result_hi <= '0;
                    result_lo <= {{32{prod[31]}}, prod[31:0]};
                end else begin
                    result_hi <= prod[127:64];
                    result_lo <= prod[63:0];
                end
            end
        end
    end

endmodule
